ps2_key_event_decoder: RTL

Parametrised PS/2 scan-code-set-2 keystroke translator between the PS/2 receiver's byte output and character consumers (VGA text terminal, seven-segment display). Parses make, break (F0) and extended (E0) sequences. Tracks shift, caps-lock and ctrl state, and converts make codes to ASCII with case and control-code handling. Queues the resulting characters in a show-ahead FIFO with a pop handshake and keeps key-held status and a press counter.

---
 rtl/kbd_pkg.sv | 95 +++++++++
 rtl/kbd_char_fifo.sv | 58 +++++
 rtl/ps2_key_event_decoder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared types, scan codes and ASCII lookup for the PS/2 key event decoder
// Purpose: parser state enum, scan-code-set-2 prefix/modifier constants and the
//          scan2ascii lookup used by ps2_key_event_decoder.
// Ports:   none (package).
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_e;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef struct packed {
    logic       hit;
    logic       is_letter;
    logic [7:0] ascii;
  } kbd_map_t;

  // Letters are returned lowercase; case and ctrl folding are applied by the caller.
  function automatic kbd_map_t scan2ascii(input logic [7:0] code, input logic ext);
    kbd_map_t m;
    m.hit       = 1'b1;
    m.is_letter = 1'b0;
    m.ascii     = 8'h00;
    if (ext) begin
      if (code == 8'h5A) m.ascii = 8'h0D;  // keypad enter
      else m.hit = 1'b0;
    end else begin
      case (code)
        8'h1C: m.ascii = 8'h61;  // a
        8'h32: m.ascii = 8'h62;
        8'h21: m.ascii = 8'h63;
        8'h23: m.ascii = 8'h64;
        8'h24: m.ascii = 8'h65;
        8'h2B: m.ascii = 8'h66;
        8'h34: m.ascii = 8'h67;
        8'h33: m.ascii = 8'h68;
        8'h43: m.ascii = 8'h69;
        8'h3B: m.ascii = 8'h6A;
        8'h42: m.ascii = 8'h6B;
        8'h4B: m.ascii = 8'h6C;
        8'h3A: m.ascii = 8'h6D;
        8'h31: m.ascii = 8'h6E;
        8'h44: m.ascii = 8'h6F;
        8'h4D: m.ascii = 8'h70;
        8'h15: m.ascii = 8'h71;
        8'h2D: m.ascii = 8'h72;
        8'h1B: m.ascii = 8'h73;
        8'h2C: m.ascii = 8'h74;
        8'h3C: m.ascii = 8'h75;
        8'h2A: m.ascii = 8'h76;
        8'h1D: m.ascii = 8'h77;
        8'h22: m.ascii = 8'h78;
        8'h35: m.ascii = 8'h79;
        8'h1A: m.ascii = 8'h7A;  // z
        8'h45: m.ascii = 8'h30;  // 0
        8'h16: m.ascii = 8'h31;
        8'h1E: m.ascii = 8'h32;
        8'h26: m.ascii = 8'h33;
        8'h25: m.ascii = 8'h34;
        8'h2E: m.ascii = 8'h35;
        8'h36: m.ascii = 8'h36;
        8'h3D: m.ascii = 8'h37;
        8'h3E: m.ascii = 8'h38;
        8'h46: m.ascii = 8'h39;  // 9
        8'h4E: m.ascii = 8'h2D;  // -
        8'h55: m.ascii = 8'h3D;  // =
        8'h54: m.ascii = 8'h5B;  // [
        8'h5B: m.ascii = 8'h5D;  // ]
        8'h4C: m.ascii = 8'h3B;  // ;
        8'h52: m.ascii = 8'h27;  // '
        8'h41: m.ascii = 8'h2C;  // ,
        8'h49: m.ascii = 8'h2E;  // .
        8'h4A: m.ascii = 8'h2F;  // /
        8'h5D: m.ascii = 8'h5C;  // backslash
        8'h29: m.ascii = 8'h20;  // space
        8'h5A: m.ascii = 8'h0D;  // enter
        8'h66: m.ascii = 8'h08;  // backspace
        8'h0D: m.ascii = 8'h09;  // tab
        default: m.hit = 1'b0;
      endcase
    end
    m.is_letter = m.hit && (m.ascii >= 8'h61) && (m.ascii <= 8'h7A);
    return m;
  endfunction

endpackage

// File: rtl/kbd_char_fifo.sv
// rtl/kbd_char_fifo.sv - show-ahead character FIFO for the PS/2 key event decoder
// Purpose: synchronous FIFO, DEPTH x 8 bits; head is visible on rd_data while !empty.
// Ports:   clk, clrn (async active-low reset), wr_en/wr_data (push),
//          rd_en (pop head, ignored when empty), rd_data (head, 0x00 when empty),
//          full, empty.
module kbd_char_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop on the same edge frees the slot, so a push into a full FIFO is accepted.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ps2_key_event_decoder.sv
// rtl/ps2_key_event_decoder.sv - PS/2 set-2 scan code to ASCII keystroke decoder
// Purpose: parses make/break/extended sequences, tracks shift/caps/ctrl, maps
//          makes to ASCII and queues characters in a show-ahead FIFO.
// Ports:   clk, clrn (async active-low reset), code_valid/code (scan byte in),
//          rd_en (pop), ascii/ascii_valid (FIFO head), overflow (sticky drop),
//          shift, caps, ctrl, key_down, last_code, press_cnt (successful pushes).
// Config:  KBD_REPEAT_FILTER_EN - when defined, typematic repeats of the held
//          key are neither pushed nor counted.
module ps2_key_event_decoder
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             code_valid,
  input  logic [7:0]       code,
  input  logic             rd_en,
  output logic [7:0]       ascii,
  output logic             ascii_valid,
  output logic             overflow,
  output logic             shift,
  output logic             caps,
  output logic             ctrl,
  output logic             key_down,
  output logic [7:0]       last_code,
  output logic [CNT_W-1:0] press_cnt
);

  kbd_state_e       state_q, state_d;
  logic             lshift_q, lshift_d;
  logic             rshift_q, rshift_d;
  logic             lctrl_q, lctrl_d;
  logic             rctrl_q, rctrl_d;
  logic             caps_q, caps_d;
  logic             caps_held_q, caps_held_d;
  logic             key_down_q, key_down_d;
  logic [7:0]       last_code_q, last_code_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;

  kbd_map_t         map;
  logic             ext_byte;
  logic             is_make, is_break, is_repeat;
  logic             push, push_ok;
  logic [7:0]       push_char;
  logic             fifo_full, fifo_empty;

  assign ext_byte = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
  assign map      = scan2ascii(code, ext_byte);

`ifdef KBD_REPEAT_FILTER_EN
  assign is_repeat = key_down_q && (code == last_code_q);
`else
  assign is_repeat = 1'b0;
`endif

  // Case folding: ctrl wins over shift/caps; non-letters pass through.
  always_comb begin
    push_char = map.ascii;
    if (map.is_letter) begin
      if (lctrl_q || rctrl_q)            push_char = map.ascii & 8'h1F;
      else if ((lshift_q || rshift_q) ^ caps_q) push_char = map.ascii & 8'hDF;
    end
  end

  always_comb begin
    state_d     = state_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    lctrl_d     = lctrl_q;
    rctrl_d     = rctrl_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    key_down_d  = key_down_q;
    last_code_d = last_code_q;
    is_make     = 1'b0;
    is_break    = 1'b0;
    push        = 1'b0;

    if (code_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (code == SC_BREAK)    state_d = ST_BRK;
          else if (code == SC_EXT) state_d = ST_EXT;
          else                     is_make = 1'b1;
        end
        ST_EXT: begin
          if (code == SC_BREAK) state_d = ST_EXT_BRK;
          else begin
            state_d = ST_IDLE;
            is_make = 1'b1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          is_break = 1'b1;
        end
      endcase
    end

    if (is_make) begin
      if (!ext_byte && code == SC_LSHIFT)      lshift_d = 1'b1;
      else if (!ext_byte && code == SC_RSHIFT) rshift_d = 1'b1;
      else if (code == SC_CTRL) begin
        if (ext_byte) rctrl_d = 1'b1;
        else          lctrl_d = 1'b1;
      end else if (!ext_byte && code == SC_CAPS) begin
        // caps_held blocks typematic repeats of caps-lock from re-toggling.
        if (!caps_held_q) caps_d = ~caps_q;
        caps_held_d = 1'b1;
      end else if (map.hit && !is_repeat) begin
        key_down_d  = 1'b1;
        last_code_d = code;
        push        = 1'b1;
      end
    end

    if (is_break) begin
      if (!ext_byte && code == SC_LSHIFT) lshift_d = 1'b0;
      if (!ext_byte && code == SC_RSHIFT) rshift_d = 1'b0;
      if (code == SC_CTRL) begin
        if (ext_byte) rctrl_d = 1'b0;
        else          lctrl_d = 1'b0;
      end
      if (!ext_byte && code == SC_CAPS) caps_held_d = 1'b0;
      if (code == last_code_q) key_down_d = 1'b0;
    end
  end

  // A pop on the same edge makes room, so full+push+pop loses nothing.
  assign push_ok = push && (!fifo_full || rd_en);

  always_comb begin
    overflow_d  = overflow_q | (push && fifo_full && !rd_en);
    press_cnt_d = press_cnt_q;
    if (push_ok) press_cnt_d = press_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      key_down_q  <= 1'b0;
      last_code_q <= 8'h00;
      overflow_q  <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      lctrl_q     <= lctrl_d;
      rctrl_q     <= rctrl_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      key_down_q  <= key_down_d;
      last_code_q <= last_code_d;
      overflow_q  <= overflow_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  kbd_char_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .clrn   (clrn),
    .wr_en  (push_ok),
    .wr_data(push_char),
    .rd_en  (rd_en),
    .rd_data(ascii),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign ascii_valid = !fifo_empty;
  assign overflow    = overflow_q;
  assign shift       = lshift_q | rshift_q;
  assign caps        = caps_q;
  assign ctrl        = lctrl_q | rctrl_q;
  assign key_down    = key_down_q;
  assign last_code   = last_code_q;
  assign press_cnt   = press_cnt_q;

endmodule
